// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator behind a
// valid/ready handshake with a 2-entry skid buffer.
//
// The immediate format is decoded from the opcode alone. The immediate is
// sign-extended from instr[31] to XLEN (U included, so lui/auipc on RV64
// produce the architecturally correct value). A pass-through tag travels
// with each instruction, and a saturating counter tracks accepted illegal
// opcodes.
//
// Optional feature macro: IMM_GEN_CSR_EN
//   defined   : SYSTEM opcode decodes as CSR-immediate (fmt 6, zero-extended
//               uimm) when funct3[2]=1, otherwise as an I-type immediate.
//   undefined : SYSTEM opcode is treated as illegal.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid/ready   input handshake; in_ready is a pure register output
//   in_instr, in_tag instruction word and sideband tag
//   out_valid/ready  output handshake
//   out_imm          sign-extended immediate (XLEN bits)
//   out_fmt          0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR, 7 illegal
//   out_tag          tag belonging to out_imm
//   illegal_cnt      saturating count of accepted illegal opcodes
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
`ifdef IMM_GEN_CSR_EN
  localparam logic [2:0] FMT_CSR = 3'd6;
`endif
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  // Every format is first assembled as a 32-bit value already extended
  // from instr[31]; widening to XLEN then only replicates that sign.
  function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic signed [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [2:0]              out_fmt_q, out_fmt_d;
  logic [TAG_W-1:0]        out_tag_q, out_tag_d;
  logic signed [XLEN-1:0]  skid_imm_q;
  logic [2:0]              skid_fmt_q;
  logic [TAG_W-1:0]        skid_tag_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic signed [XLEN-1:0]  dec_imm;
  logic [2:0]              dec_fmt;
  logic                    accept, drain;
  logic                    out_load_in, out_load_skid, skid_load;

  // ---- stage p0: opcode decode of the offered instruction
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_ILL;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = sext32({in_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0});
      end
      7'b0110011: begin
        dec_fmt = FMT_R;
        dec_imm = '0;
      end
      7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
        // funct3[2] selects the immediate CSR forms (CSRR*I).
        if (in_instr[14]) begin
          dec_fmt = FMT_CSR;
          dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
        end else begin
          dec_fmt = FMT_I;
          dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        end
`else
        dec_fmt = FMT_ILL;
        dec_imm = '0;
`endif
      end
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

  // Skid control. in_ready is registered from the next state, so it never
  // depends combinationally on out_ready; the skid entry absorbs the one
  // instruction that can arrive while the output is stalled.
  always_comb begin
    state_d       = state_q;
    out_load_in   = 1'b0;
    out_load_skid = 1'b0;
    skid_load     = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d     = S_ONE;
          out_load_in = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          out_load_in = 1'b1;
        end else if (accept) begin
          state_d   = S_FULL;
          skid_load = 1'b1;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drain) begin
          state_d       = S_ONE;
          out_load_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready_d = (state_d != S_FULL);
    out_imm_d  = out_imm_q;
    out_fmt_d  = out_fmt_q;
    out_tag_d  = out_tag_q;
    if (out_load_in) begin
      out_imm_d = dec_imm;
      out_fmt_d = dec_fmt;
      out_tag_d = in_tag;
    end else if (out_load_skid) begin
      out_imm_d = skid_imm_q;
      out_fmt_d = skid_fmt_q;
      out_tag_d = skid_tag_q;
    end
    cnt_d = cnt_q;
    if (accept && (dec_fmt == FMT_ILL)) cnt_d = sat_inc(cnt_q);
  end

  // ---- stage p1: output register, control state and illegal counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b0;
      out_imm_q  <= '0;
      out_fmt_q  <= '0;
      out_tag_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_imm_q  <= out_imm_d;
      out_fmt_q  <= out_fmt_d;
      out_tag_q  <= out_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  // Skid data is only read when the FSM says it is occupied, so it needs
  // no reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_imm_q <= dec_imm;
      skid_fmt_q <= dec_fmt;
      skid_tag_q <= in_tag;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != S_EMPTY);
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_tag     = out_tag_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_tag = 32'h0;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32, out_tag32, out_tag64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt32, out_fmt64;
  logic [1:0]  cnt32;
  logic [7:0]  cnt64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_tag(out_tag32), .illegal_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_tag(out_tag64), .illegal_cnt(cnt64));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference decode: field values are gathered with shifts and masks and
  // then made negative by subtracting 2^width when instr[31] is set.
  function automatic void ref_dec(input logic [31:0] ins, output logic [63:0] imm,
                                  output logic [2:0] fmt);
    longint u, v;
    u = {32'b0, ins};
    v = 0;
    fmt = 3'd7;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin
        fmt = 3'd1; v = (u >> 20) & 4095; if (ins[31]) v = v - 4096;
      end
      7'h23: begin
        fmt = 3'd2; v = ((u >> 25) & 127) * 32 + ((u >> 7) & 31);
        if (ins[31]) v = v - 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32
            + ((u >> 8) & 15) * 2;
        if (ins[31]) v = v - 8192;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4; v = u & 64'hFFFF_F000; if (ins[31]) v = v - 64'sh1_0000_0000;
      end
      7'h6f: begin
        fmt = 3'd5;
        v = ((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096
            + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
        if (ins[31]) v = v - 2097152;
      end
      7'h33: fmt = 3'd0;
      7'h73: begin
`ifdef IMM_GEN_CSR_EN
        if (((u >> 14) & 1) == 1) begin
          fmt = 3'd6; v = (u >> 15) & 31;
        end else begin
          fmt = 3'd1; v = (u >> 20) & 4095; if (ins[31]) v = v - 4096;
        end
`else
        fmt = 3'd7;
`endif
      end
      default: fmt = 3'd7;
    endcase
    imm = v;
  endfunction

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64, ea;
  logic [1:0] mc32 = 2'd0;
  int         mc64 = 0;
  bit         fresh = 1'b1;

  // Scoreboard: at each falling edge the handshakes that will complete on
  // the next rising edge are known, so drains are checked against the FIFO
  // model and accepts are pushed into it.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      q32.delete(); q64.delete();
      mc32 = 2'd0; mc64 = 0; fresh = 1'b1;
    end else begin
      chk("valid32", out_valid32, q32.size() != 0);
      chk("valid64", out_valid64, q64.size() != 0);
      if (!fresh) begin
        chk("ready32", in_ready32, q32.size() < 2);
        chk("ready64", in_ready64, q64.size() < 2);
      end
      chk("cnt32", cnt32, mc32);
      chk("cnt64", cnt64, mc64);
      if (out_valid32 && out_ready && q32.size() != 0) begin
        e32 = q32.pop_front();
        chk("imm32", out_imm32, e32.imm[31:0]);
        chk("fmt32", out_fmt32, e32.fmt);
        chk("tag32", out_tag32, e32.tag);
      end
      if (out_valid64 && out_ready && q64.size() != 0) begin
        e64 = q64.pop_front();
        chk("imm64", out_imm64, e64.imm);
        chk("fmt64", out_fmt64, e64.fmt);
        chk("tag64", out_tag64, e64.tag);
      end
      if (in_valid) begin
        ref_dec(in_instr, ea.imm, ea.fmt);
        ea.tag = in_tag;
        if (in_ready32) begin
          q32.push_back(ea);
          if (ea.fmt == 3'd7 && mc32 != 2'd3) mc32 = mc32 + 2'd1;
        end
        if (in_ready64) begin
          q64.push_back(ea);
          if (ea.fmt == 3'd7 && mc64 != 255) mc64 = mc64 + 1;
        end
      end
      fresh = 1'b0;
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 16 && in_ready32 !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk("ready_wait", in_ready32, 1'b1);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  vec_t       tbl[12];
  logic [6:0] ops[12];
  logic [31:0] r;
  logic [6:0]  op;
  logic        rdy_s;

  initial begin
    tbl[0]  = '{32'h0080af03, 64'h0000000000000008, 3'd1};
    tbl[1]  = '{32'hfe20aa23, 64'hfffffffffffffff4, 3'd2};
    tbl[2]  = '{32'hfeb289e3, 64'hfffffffffffffff2, 3'd3};
    tbl[3]  = '{32'hff80af03, 64'hfffffffffffffff8, 3'd1};
    tbl[4]  = '{32'h80000037, 64'hffffffff80000000, 3'd4};
    tbl[5]  = '{32'h0080006f, 64'h0000000000000008, 3'd5};
    tbl[6]  = '{32'h002081b3, 64'h0000000000000000, 3'd0};
    tbl[7]  = '{32'h0000007f, 64'h0000000000000000, 3'd7};
`ifdef IMM_GEN_CSR_EN
    tbl[8]  = '{32'h3401d073, 64'h0000000000000003, 3'd6};
    tbl[9]  = '{32'h34011073, 64'h0000000000000340, 3'd1};
`else
    tbl[8]  = '{32'h3401d073, 64'h0000000000000000, 3'd7};
    tbl[9]  = '{32'h34011073, 64'h0000000000000000, 3'd7};
`endif
    tbl[10] = '{32'hfffff097, 64'hfffffffffffff000, 3'd4};
    tbl[11] = '{32'h800000e7, 64'hfffffffffffff800, 3'd1};
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h73, 7'h7f, 7'h00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid32", out_valid32, 1'b0);
    chk("rst_ready32", in_ready32, 1'b0);
    chk("rst_imm32", out_imm32, 32'h0);
    chk("rst_fmt32", out_fmt32, 3'd0);
    chk("rst_tag32", out_tag32, 32'h0);
    chk("rst_cnt32", cnt32, 2'd0);
    chk("rst_valid64", out_valid64, 1'b0);
    chk("rst_imm64", out_imm64, 64'h0);
    rst = 1'b0;

    // Illegal counter saturation at CNT_W=2
    wait_ready();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_instr = 32'h0000007f; in_tag = i; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("ill_cnt32", cnt32, (i < 2) ? i + 1 : 3);
      chk("ill_cnt64", cnt64, i + 1);
      chk("ill_fmt32", out_fmt32, 3'd7);
      chk("ill_imm32", out_imm32, 32'h0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Table of known encodings, back to back with 1-cycle latency
    for (int i = 0; i < 12; i++) begin
      in_instr = tbl[i].instr; in_tag = 32'h100 + i; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("tbl_valid", out_valid32, 1'b1);
      chk("tbl_imm32", out_imm32, tbl[i].imm[31:0]);
      chk("tbl_imm64", out_imm64, tbl[i].imm);
      chk("tbl_fmt32", out_fmt32, tbl[i].fmt);
      chk("tbl_fmt64", out_fmt64, tbl[i].fmt);
      chk("tbl_tag", out_tag32, 32'h100 + i);
      chk("tbl_ready", in_ready32, 1'b1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: tags 1,2,3 with output stalled
    out_ready = 1'b0;
    in_instr = 32'h00100013; in_tag = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_a", in_ready32, 1'b1);
    chk("bp_tag_a", out_tag32, 32'd1);
    in_tag = 32'd2;
    @(posedge clk); #1;
    chk("bp_ready_b", in_ready32, 1'b0);
    chk("bp_tag_b", out_tag32, 32'd1);
    in_tag = 32'd3;
    @(posedge clk); #1;
    chk("bp_ready_c", in_ready32, 1'b0);
    chk("bp_tag_c", out_tag32, 32'd1);
    chk("bp_valid_c", out_valid32, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_tag_d", out_tag32, 32'd2);
    chk("bp_ready_d", in_ready32, 1'b1);
    @(posedge clk); #1;
    chk("bp_tag_e", out_tag32, 32'd3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_valid_f", out_valid32, 1'b0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_instr = 32'h0000007f; in_tag = 32'hA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_instr = 32'h00100013; in_tag = 32'hB;
    @(posedge clk); #1;
    chk("full_ready", in_ready32, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid32", out_valid32, 1'b0);
    chk("arst_valid64", out_valid64, 1'b0);
    chk("arst_cnt32", cnt32, 2'd0);
    chk("arst_ready32", in_ready32, 1'b0);
    chk("arst_tag32", out_tag32, 32'h0);
    rst = 1'b0;
    wait_ready();
    in_instr = 32'h0080af03; in_tag = 32'h55; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", out_valid32, 1'b1);
    chk("post_imm", out_imm32, 32'h8);
    chk("post_tag", out_tag32, 32'h55);
    in_valid = 1'b0;

    // Randomised traffic with random stalls on both sides
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rdy_s = in_ready32;
      @(posedge clk); #1;
      if (!(in_valid && !rdy_s)) begin
        r = $urandom();
        op = ops[$urandom_range(11)];
        if (op == 7'h00) op = 7'($urandom());
        in_valid = ($urandom_range(3) != 0);
        in_instr = {r[31:7], op};
        in_tag = $urandom();
      end
      out_ready = ($urandom_range(2) != 0);
    end

    // Drain everything
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_valid32", out_valid32, 1'b0);
    chk("drain_valid64", out_valid64, 1'b0);
    chk("drain_q32", q32.size(), 0);
    chk("drain_q64", q64.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised successor to the combinational immediate generator. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, plus R as zero) from the opcode alone, with no external format select. Output is sign-extended to XLEN. The block sits between fetch and decode behind a valid/ready handshake, with a 2-entry skid buffer so backpressure never drops or reorders instructions. It also carries a pass-through tag (e.g. PC) and keeps a saturating illegal-opcode counter.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 32, width of the pass-through tag.
CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  instruction offered.
in_ready  output  1  block can accept this cycle.
in_instr  input  32  raw instruction word.
in_tag  input  TAG_W  sideband carried with the instruction.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts this cycle.
out_imm  output  XLEN  sign-extended immediate.
out_fmt  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR, 7 illegal.
out_tag  output  TAG_W  tag of the instruction in out_imm.
illegal_cnt  output  CNT_W  count of accepted illegal opcodes; saturates.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_imm=0, out_fmt=0, out_tag=0, skid empty, in_ready=0 while rst is high, illegal_cnt=0. Asserting reset mid-transfer discards all held entries.
- Decode by opcode in_instr[6:0]:
  - 0000011 / 0010011 / 1100111 -> I: instr[31:20].
  - 0100011 -> S: {instr[31:25], instr[11:7]}.
  - 1100011 -> B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111 / 0010111 -> U: {instr[31:12], 12'b0}.
  - 1101111 -> J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 0110011 -> R: imm = 0.
  - 1110011 -> see the optional feature.
  - Any other opcode -> fmt 7, imm 0.
- Width rule: every format sign-extends from its top bit (instr[31]) to XLEN, including U when XLEN=64.
- Handshake: a transfer happens when valid and ready are both high on a rising edge. The producer holds in_instr/in_tag stable while in_valid=1 and in_ready=0. out_* stay stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from input accept to out_valid when the pipe is empty.
- State machine:
  - EMPTY: out_valid=0, in_ready=1. On accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - accept and drain together -> ONE (output register reloads).
    - accept only -> FULL (new entry goes to skid).
    - drain only -> EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - On drain, skid moves to the output register -> ONE.
- in_ready is a register output. It has no combinational path from out_ready.
- Ordering is strictly FIFO; no entry is ever dropped or duplicated.
- illegal_cnt increments by 1 on each accepted fmt-7 instruction. It holds at 2^CNT_W-1 and never wraps.

Optional Feature:
IMM_GEN_CSR_EN
- Defined: opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> fmt 6, imm = zero-extended uimm instr[19:15]. Other 1110011 encodings -> fmt 1, imm = instr[31:20] sign-extended.
- Undefined: every 1110011 encoding -> fmt 7, imm 0, and illegal_cnt increments.

Test Plan:
1. XLEN=32, out_ready=1, back-to-back 0x0080af03, 0xfe20aa23, 0xfeb289e3 -> imm 0x00000008 fmt1; 0xfffffff4 fmt2; 0xfffffff2 fmt3. One per cycle, 1-cycle latency, in_ready stays 1.
2. XLEN=64: 0xff80af03 -> 0xfffffffffffffff8; lui 0x80000037 -> 0xffffffff80000000 fmt4; jal 0x0080006f -> 0x0000000000000008 fmt5.
3. Backpressure: out_ready=0, offer tags 1,2,3 -> tag1 in output, tag2 in skid, in_ready=0 from the cycle after accept 2, tag3 held. Then raise out_ready -> outputs tags 1,2,3 in order, none lost.
4. Illegal: CNT_W=2, six instructions with opcode 0x7f accepted -> fmt 7, imm 0, illegal_cnt goes 1,2,3,3,3,3.
5. Assert rst while in FULL -> out_valid=0 immediately (async), illegal_cnt=0. After release, first new instruction appears with 1-cycle latency.
6. With IMM_GEN_CSR_EN: csrrwi 0x3401d073 (uimm 3) -> fmt 6, imm 3. Without the macro -> fmt 7, imm 0, illegal_cnt +1.
